// File: rtl/hazard_fwd_ctl_if.sv
// Decode/EXE side bundle of the hazard and forwarding controller.
// master drives decode state and stage results; slave is the controller.
interface hazard_fwd_ctl_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  logic                  de_valid;
  logic [AW-1:0]         de_rs1;
  logic [AW-1:0]         de_rs2;
  logic                  de_rs1_used;
  logic                  de_rs2_used;
  logic [AW-1:0]         de_rd;
  logic                  de_wen;
  logic                  de_load;
  logic                  flush;
  logic [DEPTH*XLEN-1:0] stage_res;

  logic                  stall;
  logic                  ex_valid;
  logic                  fwd_hit_a;
  logic                  fwd_hit_b;
  logic [XLEN-1:0]       fwd_data_a;
  logic [XLEN-1:0]       fwd_data_b;
  logic [SW-1:0]         fwd_src_a;
  logic [SW-1:0]         fwd_src_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output de_valid, de_rs1, de_rs2,
    output de_rs1_used, de_rs2_used,
    output de_rd, de_wen, de_load,
    output flush, stage_res,
    input  stall, ex_valid,
    input  fwd_hit_a, fwd_hit_b,
    input  fwd_data_a, fwd_data_b,
    input  fwd_src_a, fwd_src_b,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2,
    input  de_rs1_used, de_rs2_used,
    input  de_rd, de_wen, de_load,
    input  flush, stage_res,
    output stall, ex_valid,
    output fwd_hit_a, fwd_hit_b,
    output fwd_data_a, fwd_data_b,
    output fwd_src_a, fwd_src_b,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctl.sv
// Writer scoreboard over DEPTH post-decode stages: load-use stall,
// youngest-first operand forwarding, branch flush and event counters.
module hazard_fwd_ctl #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_fwd_ctl_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] rd;
    logic          load;
  } sb_t;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ret_t;

  typedef struct packed {
    logic            hit;
    logic [SW-1:0]   src;
    logic [XLEN-1:0] data;
  } fwd_t;

  sb_t  [DEPTH-1:0] sb_q;
  ret_t             ret_q;
  logic [AW-1:0]    ex_rs1_q, ex_rs2_q;
  logic             ex_u1_q, ex_u2_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic stall_raw, stall, adv, ex_valid;
  fwd_t fa, fb;

  function automatic logic wr_hit(
    sb_t e, logic [AW-1:0] src, logic used
  );
    return e.valid && e.wen && used &&
           (e.rd == src) && (e.rd != '0);
  endfunction

  // Youngest stage first, retired buffer last.
  function automatic fwd_t fwd_sel(
    sb_t [DEPTH-1:0] sb, ret_t rb,
    logic [DEPTH*XLEN-1:0] res,
    logic [AW-1:0] src, logic used
  );
    fwd_t f;
    f = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (!f.hit && wr_hit(sb[i], src, used)) begin
        f.hit  = 1'b1;
        f.src  = SW'(i);
        f.data = res[i*XLEN +: XLEN];
      end
    end
    if (!f.hit && rb.valid && used &&
        (rb.rd == src) && (rb.rd != '0)) begin
      f.hit  = 1'b1;
      f.src  = SW'(DEPTH);
      f.data = rb.data;
    end
    return f;
  endfunction

  always_comb begin
    logic found;
    found     = 1'b0;
    stall_raw = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!found &&
          (wr_hit(sb_q[j], bus.de_rs1, bus.de_rs1_used) ||
           wr_hit(sb_q[j], bus.de_rs2, bus.de_rs2_used))) begin
        found     = 1'b1;
        stall_raw = sb_q[j].load && (j + 1 < LOAD_STAGE);
      end
    end
  end

  assign stall    = bus.de_valid && stall_raw && !bus.flush;
  assign adv      = bus.de_valid && !stall && !bus.flush;
  assign ex_valid = sb_q[0].valid;

  always_comb begin
    fa = '0;
    fb = '0;
    if (ex_valid) begin
      fa = fwd_sel(sb_q, ret_q, bus.stage_res,
                   ex_rs1_q, ex_u1_q);
      fb = fwd_sel(sb_q, ret_q, bus.stage_res,
                   ex_rs2_q, ex_u2_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q        <= '0;
      ret_q       <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_u1_q     <= 1'b0;
      ex_u2_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
      if (adv) begin
        sb_q[0]  <= {1'b1, bus.de_wen, bus.de_rd,
                     bus.de_load};
        ex_rs1_q <= bus.de_rs1;
        ex_rs2_q <= bus.de_rs2;
        ex_u1_q  <= bus.de_rs1_used;
        ex_u2_q  <= bus.de_rs2_used;
      end else begin
        sb_q[0]  <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
        ex_u1_q  <= 1'b0;
        ex_u2_q  <= 1'b0;
      end
      // Keeps the last WB write visible for a same-cycle regfile read.
      if (sb_q[DEPTH-1].valid && sb_q[DEPTH-1].wen) begin
        ret_q <= {1'b1, sb_q[DEPTH-1].rd,
                  bus.stage_res[(DEPTH-1)*XLEN +: XLEN]};
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (bus.flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall      = stall;
  assign bus.ex_valid   = ex_valid;
  assign bus.fwd_hit_a  = fa.hit;
  assign bus.fwd_hit_b  = fb.hit;
  assign bus.fwd_data_a = fa.data;
  assign bus.fwd_data_b = fb.data;
  assign bus.fwd_src_a  = fa.src;
  assign bus.fwd_src_b  = fb.src;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctl.sv
// Directed bench for hazard_fwd_ctl: expectations queued at drive time,
// popped and asserted against the DUT outputs mid-cycle.
module tb_hazard_fwd_ctl;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int LS    = 2;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_ctl_if #(
    .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .CNT_W(CW)
  ) bus ();

  hazard_fwd_ctl #(
    .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH),
    .LOAD_STAGE(LS), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum {
    O_STALL, O_EXV, O_HITA, O_HITB, O_DA, O_DB,
    O_SA, O_SB, O_SCNT, O_FCNT
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sr [DEPTH];

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      O_STALL: return 32'(bus.stall);
      O_EXV:   return 32'(bus.ex_valid);
      O_HITA:  return 32'(bus.fwd_hit_a);
      O_HITB:  return 32'(bus.fwd_hit_b);
      O_DA:    return bus.fwd_data_a;
      O_DB:    return bus.fwd_data_b;
      O_SA:    return 32'(bus.fwd_src_a);
      O_SB:    return 32'(bus.fwd_src_b);
      O_SCNT:  return 32'(bus.stall_cnt);
      default: return 32'(bus.flush_cnt);
    endcase
  endfunction

  task automatic ex(string tag, sel_e s, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] o;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h",
               e.tag, o, e.val);
      end
    end
  endtask

  task automatic set_sr();
    for (int i = 0; i < DEPTH; i++) begin
      bus.stage_res[i*XLEN +: XLEN] = sr[i];
    end
  endtask

  task automatic dec(
    logic v, logic [4:0] rs1, logic u1,
    logic [4:0] rs2, logic u2,
    logic [4:0] rd, logic w, logic ld
  );
    bus.de_valid    = v;
    bus.de_rs1      = rs1;
    bus.de_rs1_used = u1;
    bus.de_rs2      = rs2;
    bus.de_rs2_used = u2;
    bus.de_rd       = rd;
    bus.de_wen      = w;
    bus.de_load     = ld;
  endtask

  task automatic idle();
    dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush = 1'b0;
    idle();
    sr[0] = 32'h0000_0011;
    sr[1] = 32'h0000_0042;
    sr[2] = 32'hDEAD_BEEF;
    set_sr();

    #12;
    ex("rst_stall", O_STALL, 0);
    ex("rst_exv",   O_EXV,   0);
    ex("rst_scnt",  O_SCNT,  0);
    ex("rst_fcnt",  O_FCNT,  0);
    ex("rst_hita",  O_HITA,  0);
    ex("rst_da",    O_DA,    0);
    ex("rst_sa",    O_SA,    0);
    check_q();
    rst = 1'b1;
    cyc();

    // add x5 ; sub x6,x5,x1
    dec(1, 1, 1, 2, 1, 5, 1, 0);
    ex("add_nostall", O_STALL, 0);
    check_q();
    cyc();
    dec(1, 5, 1, 1, 1, 6, 1, 0);
    ex("sub_nostall", O_STALL, 0);
    ex("add_exv",     O_EXV,   1);
    ex("add_nohit",   O_HITA,  0);
    check_q();
    cyc();
    idle();
    ex("alu_hita", O_HITA, 1);
    ex("alu_sa",   O_SA,   1);
    ex("alu_da",   O_DA,   32'h0000_0042);
    ex("alu_hitb", O_HITB, 0);
    check_q();
    repeat (4) cyc();

    // lw x7 ; add x8,x7,x7
    dec(1, 2, 1, 0, 0, 7, 1, 1);
    ex("lw_nostall", O_STALL, 0);
    check_q();
    cyc();
    dec(1, 7, 1, 7, 1, 8, 1, 0);
    ex("lu_stall", O_STALL, 1);
    check_q();
    cyc();
    ex("lu_release", O_STALL, 0);
    ex("lu_scnt",    O_SCNT,  1);
    check_q();
    cyc();
    idle();
    ex("lu_hita", O_HITA, 1);
    ex("lu_hitb", O_HITB, 1);
    ex("lu_sa",   O_SA,   2);
    ex("lu_sb",   O_SB,   2);
    ex("lu_da",   O_DA,   32'hDEAD_BEEF);
    ex("lu_db",   O_DB,   32'hDEAD_BEEF);
    check_q();
    repeat (4) cyc();

    // x3 (old), x0, x3 (young), consumer reads x0 and x3
    dec(1, 1, 1, 0, 0, 3, 1, 0);
    cyc();
    dec(1, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    dec(1, 1, 1, 0, 0, 3, 1, 0);
    cyc();
    dec(1, 0, 1, 3, 1, 9, 1, 0);
    ex("x3_nostall", O_STALL, 0);
    check_q();
    cyc();
    idle();
    ex("x0_hita", O_HITA, 0);
    ex("x0_sa",   O_SA,   0);
    ex("x0_da",   O_DA,   0);
    ex("x3_hitb", O_HITB, 1);
    ex("x3_sb",   O_SB,   1);
    ex("x3_db",   O_DB,   32'h0000_0042);
    check_q();
    repeat (4) cyc();

    // flush wins over a load-use condition
    dec(1, 1, 1, 0, 0, 9, 1, 1);
    cyc();
    dec(1, 9, 1, 0, 0, 10, 1, 0);
    bus.flush = 1'b1;
    ex("flush_prio", O_STALL, 0);
    check_q();
    cyc();
    bus.flush = 1'b0;
    idle();
    ex("flush_exv",  O_EXV,  0);
    ex("flush_fcnt", O_FCNT, 1);
    ex("flush_scnt", O_SCNT, 1);
    check_q();
    repeat (4) cyc();

    // writer retires from WB, consumer in EXE the cycle after
    dec(1, 1, 1, 0, 0, 11, 1, 0);
    cyc();
    idle();
    cyc();
    cyc();
    sr[2] = 32'hCAFE_F00D;
    set_sr();
    dec(1, 11, 1, 0, 0, 12, 1, 0);
    cyc();
    sr[2] = 32'h1234_5678;
    set_sr();
    idle();
    ex("ret_hita", O_HITA, 1);
    ex("ret_sa",   O_SA,   DEPTH);
    ex("ret_da",   O_DA,   32'hCAFE_F00D);
    check_q();
    repeat (4) cyc();

    // self-dependent load held: one stall every other cycle
    for (int k = 0; k < 40; k++) begin
      dec(1, 7, 1, 0, 0, 7, 1, 1);
      cyc();
    end
    idle();
    ex("sat_scnt", O_SCNT, 15);
    check_q();
    repeat (4) cyc();

    // asynchronous reset in the middle of a stall
    dec(1, 2, 1, 0, 0, 7, 1, 1);
    cyc();
    dec(1, 7, 1, 0, 0, 8, 1, 0);
    ex("pre_rst_stall", O_STALL, 1);
    check_q();
    rst = 1'b0;
    ex("arst_stall", O_STALL, 0);
    ex("arst_exv",   O_EXV,   0);
    ex("arst_scnt",  O_SCNT,  0);
    ex("arst_fcnt",  O_FCNT,  0);
    check_q();
    #1;
    rst = 1'b1;
    idle();
    cyc();
    ex("post_rst_exv", O_EXV, 0);
    check_q();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
